// File: rtl/execute_mc_pkg.sv
// Shared opcode encodings, FSM state type and flag record for the execute units.
package execute_mc_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_INC = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_DEC = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_MUL = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_DIV = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_NOT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } exec_mc_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic dz;
  } alu_flags_t;

endpackage

// File: rtl/execute_muldiv.sv
// Iterative datapath: LSB-first shift-add multiply and restoring divide,
// one bit per cycle, WIDTH cycles per operation. lo_o/hi_o present the
// value the current iteration produces, so they are final while done_o is high.
module execute_muldiv #(
  parameter int WIDTH = 19
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  import execute_mc_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_opr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // One iteration: MUL keeps {acc, multiplier}; DIV keeps {remainder, dividend/quotient}.
  always_comb begin
    w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opr} : '0);
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opr});
    w_diff   = w_shift[WIDTH-1:0] - r_opr;
    w_hi_nxt = w_madd[WIDTH:1];
    w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_hi_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  // Iteration control: busy flag and bit counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Datapath registers: load operands on start, then step once per busy cycle.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      r_is_div <= is_div_i;
      r_opr    <= is_div_i ? b_i : a_i;
      r_lo     <= is_div_i ? a_i : b_i;
      r_hi     <= '0;
    end else if (r_busy) begin
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign done_o = r_busy && (r_cnt == LAST);
  assign lo_o   = w_lo_nxt;
  assign hi_o   = w_hi_nxt;

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute unit: single-cycle ALU plus iterative MUL/DIV behind
// a valid/ready handshake on both sides; one operation in flight.
module execute_mc #(
  parameter int WIDTH   = 19,
  parameter int OPSEL_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [OPSEL_W-1:0] op_sel_i,
  input  logic [WIDTH-1:0]   opr_a_i,
  input  logic [WIDTH-1:0]   opr_b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   alu_res_o,
  output logic [WIDTH-1:0]   alu_hi_o,
  output logic [3:0]         flags_o
);
  import execute_mc_pkg::*;

  exec_mc_state_e   r_state;
  exec_mc_state_e   w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_hi;
  alu_flags_t       r_flags;

  logic             w_hs;
  logic [WIDTH-1:0] w_addb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  alu_flags_t       w_flg;
  logic             w_defined;
  logic             w_start_md;
  logic             w_is_div;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  alu_flags_t       w_md_flg;

  function automatic logic f_ovf_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic f_ovf_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
    return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign w_hs   = valid_i && ready_o;
  assign w_addb = ((op_sel_i == OPSEL_W'(OP_INC)) || (op_sel_i == OPSEL_W'(OP_DEC)))
                  ? WIDTH'(1) : opr_b_i;
  assign w_sum  = {1'b0, opr_a_i} + {1'b0, w_addb};
  assign w_dif  = {1'b0, opr_a_i} - {1'b0, w_addb};

  // Single-cycle ALU result/flags and the decision to launch the iterative unit.
  always_comb begin
    w_res      = '0;
    w_hi       = '0;
    w_flg      = '0;
    w_defined  = 1'b1;
    w_start_md = 1'b0;
    w_is_div   = 1'b0;
    case (op_sel_i)
      OPSEL_W'(OP_ADD), OPSEL_W'(OP_INC): begin
        w_res       = w_sum[WIDTH-1:0];
        w_flg.carry = w_sum[WIDTH];
        w_flg.ovf   = f_ovf_add(opr_a_i, w_addb, w_sum[WIDTH-1:0]);
      end
      OPSEL_W'(OP_SUB), OPSEL_W'(OP_DEC): begin
        w_res       = w_dif[WIDTH-1:0];
        w_flg.carry = w_dif[WIDTH];
        w_flg.ovf   = f_ovf_sub(opr_a_i, w_addb, w_dif[WIDTH-1:0]);
      end
      OPSEL_W'(OP_OR):  w_res = opr_a_i | opr_b_i;
      OPSEL_W'(OP_AND): w_res = opr_a_i & opr_b_i;
      OPSEL_W'(OP_XOR): w_res = opr_a_i ^ opr_b_i;
      OPSEL_W'(OP_NOT): w_res = ~opr_a_i;
      OPSEL_W'(OP_MUL): w_start_md = 1'b1;
      OPSEL_W'(OP_DIV): begin
        w_is_div = 1'b1;
        if (opr_b_i == '0) begin
          // Divide by zero resolves immediately: all-ones quotient, A as remainder.
          w_res    = '1;
          w_hi     = opr_a_i;
          w_flg.dz = 1'b1;
        end else begin
          w_start_md = 1'b1;
        end
      end
      default: w_defined = 1'b0;
    endcase
    w_flg.zero = w_defined && (w_res == '0);
  end

  execute_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_hs && w_start_md),
    .is_div_i(w_is_div),
    .a_i     (opr_a_i),
    .b_i     (opr_b_i),
    .done_o  (w_md_done),
    .lo_o    (w_md_lo),
    .hi_o    (w_md_hi)
  );

  // Flags for an iterative result: MUL reports a non-zero upper half as overflow.
  always_comb begin
    w_md_flg      = '0;
    w_md_flg.zero = (w_md_lo == '0);
    w_md_flg.ovf  = (r_state == MUL) && (w_md_hi != '0);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (op_sel_i == OPSEL_W'(OP_MUL))  w_state_nxt = MUL;
          else if (w_is_div && w_start_md)   w_state_nxt = DIV;
          else                               w_state_nxt = DONE;
        end
      end
      MUL, DIV: begin
        if (w_md_done) w_state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result registers: load single-cycle results at handshake, iterative ones on completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res   <= '0;
      r_hi    <= '0;
      r_flags <= '0;
    end else if (w_hs && !w_start_md) begin
      r_res   <= w_res;
      r_hi    <= w_hi;
      r_flags <= w_flg;
    end else if (w_md_done) begin
      r_res   <= w_md_lo;
      r_hi    <= w_md_hi;
      r_flags <= w_md_flg;
    end
  end

  assign alu_res_o = r_res;
  assign alu_hi_o  = r_hi;
  assign flags_o   = r_flags;

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_execute_mc;
  import execute_mc_pkg::*;

  localparam int W = 19;
  localparam longint TWO_W = 64'd1 << W;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [3:0]   op_sel_i = '0;
  logic [W-1:0] opr_a_i = '0;
  logic [W-1:0] opr_b_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] alu_res_o;
  logic [W-1:0] alu_hi_o;
  logic [3:0]   flags_o;

  int n_checks = 0;
  int n_fail   = 0;

  execute_mc #(.WIDTH(W), .OPSEL_W(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_sel_i (op_sel_i),
    .opr_a_i  (opr_a_i),
    .opr_b_i  (opr_b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .alu_res_o(alu_res_o),
    .alu_hi_o (alu_hi_o),
    .flags_o  (flags_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - int'(TWO_W) : int'(v);
  endfunction

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] h,
                       output logic [3:0] f, output int lat);
    longint ua, ub, t;
    int     s;
    logic   c, o, d, defd;
    ua = longint'(a); ub = longint'(b);
    r = '0; h = '0; c = 0; o = 0; d = 0; defd = 1; lat = 1; t = 0; s = 0;
    case (op)
      OP_ADD: begin t = ua + ub; c = (t >= TWO_W); s = sx(a) + sx(b); end
      OP_INC: begin t = ua + 1;  c = (t >= TWO_W); s = sx(a) + 1;     end
      OP_SUB: begin t = ua - ub; c = (ua < ub);    s = sx(a) - sx(b); end
      OP_DEC: begin t = ua - 1;  c = (ua < 1);     s = sx(a) - 1;     end
      OP_OR:  t = longint'(a | b);
      OP_AND: t = longint'(a & b);
      OP_XOR: t = longint'(a ^ b);
      OP_NOT: t = longint'(~a);
      OP_MUL: begin t = ua * ub; h = t[2*W-1:W]; o = (h != 0); lat = W + 1; end
      OP_DIV: begin
        if (ub == 0) begin t = TWO_W - 1; h = a; d = 1; end
        else begin t = ua / ub; h = W'(ua % ub); lat = W + 1; end
      end
      default: defd = 0;
    endcase
    r = t[W-1:0];
    if (op == OP_ADD || op == OP_INC || op == OP_SUB || op == OP_DEC)
      o = (s > SMAX) || (s < SMIN);
    f = {defd && (r == 0), c, o, d};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one operation, verify latency and results, hold backpressure, then retire it.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
    logic [W-1:0] er, eh, sr, sh;
    logic [3:0]   ef, sf;
    int           elat, lat, guard;
    model(op, a, b, er, eh, ef, elat);
    guard = 0;
    while (!ready_o && guard < 100) begin tick(); guard++; end
    check("ready_before_issue", ready_o, 1);
    valid_i = 1; op_sel_i = op; opr_a_i = a; opr_b_i = b;
    tick();
    valid_i = 0; op_sel_i = 4'($urandom); opr_a_i = W'($urandom); opr_b_i = W'($urandom);
    lat = 1;
    while (!valid_o && lat < 100) begin
      check("ready_low_busy", ready_o, 0);
      valid_i = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    valid_i = 0;
    check("latency", lat, elat);
    check("res", alu_res_o, er);
    check("hi", alu_hi_o, eh);
    check("flags", flags_o, ef);
    check("ready_low_done", ready_o, 0);
    sr = alu_res_o; sh = alu_hi_o; sf = flags_o;
    repeat (hold) begin
      tick();
      check("bp_valid", valid_o, 1);
      check("bp_ready", ready_o, 0);
      check("bp_stable", {sr, sh, sf}, {alu_res_o, alu_hi_o, flags_o});
    end
    ready_i = 1;
    tick();
    ready_i = 0;
    check("retire_valid", valid_o, 0);
    check("retire_ready", ready_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    repeat (2) tick();
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_res", alu_res_o, 0);
    check("rst_hi", alu_hi_o, 0);
    check("rst_flags", flags_o, 0);
    rst_i = 0;

    do_op(OP_ADD, 19'h7FFFF, 19'd1, 0);
    do_op(OP_ADD, 19'h3FFFF, 19'd1, 0);
    do_op(OP_MUL, 19'd300, 19'd500, 0);
    do_op(OP_DIV, 19'd100, 19'd7, 0);
    do_op(OP_DIV, 19'd100, 19'd0, 0);
    do_op(OP_SUB, 19'd0, 19'd1, 5);
    do_op(OP_DEC, 19'h40000, 19'd0, 0);
    do_op(OP_INC, 19'h7FFFF, 19'd9, 0);
    do_op(OP_MUL, 19'h7FFFF, 19'h7FFFF, 5);
    do_op(OP_DIV, 19'h7FFFF, 19'h7FFFF, 0);
    do_op(4'd12, 19'd5, 19'd6, 0);

    // Reset in the middle of a multiply discards it.
    while (!ready_o) tick();
    valid_i = 1; op_sel_i = OP_MUL; opr_a_i = 19'd300; opr_b_i = 19'd500;
    tick();
    valid_i = 0;
    repeat (9) tick();
    check("midrst_pre_valid", valid_o, 0);
    rst_i = 1;
    tick();
    rst_i = 0;
    check("midrst_valid", valid_o, 0);
    check("midrst_ready", ready_o, 1);
    check("midrst_outs", {alu_res_o, alu_hi_o, flags_o}, 0);
    do_op(OP_ADD, 19'd2, 19'd3, 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      do_op(op, a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
